// File: rtl/ulpi_pkg.sv
// ulpi_pkg: ULPI command encodings, FSM states, register map, reset values and alias-write helpers
package ulpi_pkg;
  typedef enum logic [1:0] {
    CMD_NOOP = 2'b00,
    CMD_TX   = 2'b01,
    CMD_WR   = 2'b10,
    CMD_RD   = 2'b11
  } cmd_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_WAIT,
    S_WR_DATA,
    S_WR_STP,
    S_RD_TURN1,
    S_RD_DATA,
    S_RD_TURN2,
    S_TX,
    S_RX_TURN1,
    S_RX_DATA,
    S_RX_TURN2
  } state_t;

  localparam logic [5:0] ADDR_VID_LO = 6'h00;
  localparam logic [5:0] ADDR_VID_HI = 6'h01;
  localparam logic [5:0] ADDR_PID_LO = 6'h02;
  localparam logic [5:0] ADDR_PID_HI = 6'h03;
  localparam logic [5:0] ADDR_FUNC   = 6'h04;
  localparam logic [5:0] ADDR_IFC    = 6'h07;
  localparam logic [5:0] ADDR_OTG    = 6'h0A;
  localparam logic [5:0] ADDR_SCR    = 6'h16;

  localparam logic [7:0] RST_FUNC = 8'h41;
  localparam logic [7:0] RST_IFC  = 8'h00;
  localparam logic [7:0] RST_OTG  = 8'h06;
  localparam logic [7:0] RST_SCR  = 8'h00;

  localparam logic [7:0] FUNC_RESET_BIT = 8'h20;

  // Each register answers at base (write), base+1 (set) and base+2 (clear)
  function automatic logic alias_hit(input logic [5:0] addr, input logic [5:0] base);
    return addr >= base && addr <= base + 6'd2;
  endfunction

  function automatic logic [7:0] alias_wr(input logic we, input logic [7:0] cur, input logic [5:0] addr,
                                          input logic [5:0] base, input logic [7:0] d);
    return (!we || !alias_hit(addr, base)) ? cur :
           addr == base         ? d :
           addr == base + 6'd1  ? cur | d :
                                  cur & ~d;
  endfunction
endpackage

// File: rtl/ulpi_phy_regfile.sv
// ulpi_phy_regfile: PHY register file with write/set/clear aliases, read-only IDs and read mux
module ulpi_phy_regfile import ulpi_pkg::*; #(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic [7:0] func_ctrl
);
  logic [7:0] ifc_ctrl, otg_ctrl, scratch;

  // Commit writes; the Function Control Reset bit drops on the edge after it was written
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      func_ctrl <= RST_FUNC;
      ifc_ctrl  <= RST_IFC;
      otg_ctrl  <= RST_OTG;
      scratch   <= RST_SCR;
    end else begin
      func_ctrl <= alias_wr(we, func_ctrl & ~FUNC_RESET_BIT, addr, ADDR_FUNC, wdata);
      ifc_ctrl  <= alias_wr(we, ifc_ctrl, addr, ADDR_IFC, wdata);
      otg_ctrl  <= alias_wr(we, otg_ctrl, addr, ADDR_OTG, wdata);
      scratch   <= alias_wr(we, scratch, addr, ADDR_SCR, wdata);
    end

  // Read mux: IDs, any alias of a register, zero for unmapped addresses
  always_comb
    rdata = addr == ADDR_VID_LO        ? VENDOR_ID[7:0] :
            addr == ADDR_VID_HI        ? VENDOR_ID[15:8] :
            addr == ADDR_PID_LO        ? PRODUCT_ID[7:0] :
            addr == ADDR_PID_HI        ? PRODUCT_ID[15:8] :
            alias_hit(addr, ADDR_FUNC) ? func_ctrl :
            alias_hit(addr, ADDR_IFC)  ? ifc_ctrl :
            alias_hit(addr, ADDR_OTG)  ? otg_ctrl :
            alias_hit(addr, ADDR_SCR)  ? scratch : 8'h00;
endmodule

// File: rtl/ulpi_phy_reg_model.sv
// ulpi_phy_reg_model: ULPI PHY register-access model; define ULPI_PHY_RXCMD_EN to emit RX CMDs on linestate changes
module ulpi_phy_reg_model import ulpi_pkg::*; #(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009,
  parameter int unsigned NXT_DELAY  = 0
) (
  input  logic       ulpi_clk60_i,
  input  logic       ulpi_rst_i,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_dir_o,
  output logic       ulpi_nxt_o,
  input  logic       ulpi_stp_i,
  input  logic [1:0] linestate_i,
  output logic [7:0] func_ctrl_o
);
  localparam logic [1:0] ND = 2'(NXT_DELAY);

  state_t     state;
  cmd_t       cmd;
  logic [1:0] cnt;
  logic [5:0] addr;
  logic [7:0] wdata, rdata;
  logic       we;

`ifdef ULPI_PHY_RXCMD_EN
  logic [1:0] last_ls;
`else
  logic unused_ls;
  assign unused_ls = ^linestate_i;
`endif

  // A write only lands when the link stops it from WR_STP
  assign we = state == S_WR_STP && ulpi_stp_i;

  ulpi_phy_regfile #(.VENDOR_ID(VENDOR_ID), .PRODUCT_ID(PRODUCT_ID)) u_regfile (
    .clk       (ulpi_clk60_i),
    .rst       (ulpi_rst_i),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .func_ctrl (func_ctrl_o)
  );

  // Bus FSM with registered dir/nxt/data outputs
  always_ff @(posedge ulpi_clk60_i or posedge ulpi_rst_i)
    if (ulpi_rst_i) begin
      state       <= S_IDLE;
      cmd         <= CMD_NOOP;
      cnt         <= '0;
      addr        <= '0;
      wdata       <= '0;
      ulpi_dir_o  <= 1'b0;
      ulpi_nxt_o  <= 1'b0;
      ulpi_data_o <= 8'h00;
`ifdef ULPI_PHY_RXCMD_EN
      last_ls     <= 2'b00;
`endif
    end else begin
      case (state)
        S_IDLE:
`ifdef ULPI_PHY_RXCMD_EN
          if (linestate_i != last_ls) begin
            state      <= S_RX_TURN1;
            ulpi_dir_o <= 1'b1;
            last_ls    <= linestate_i;
          end else
`endif
          if (cmd_t'(ulpi_data_i[7:6]) != CMD_NOOP) begin
            state      <= S_CMD_WAIT;
            cmd        <= cmd_t'(ulpi_data_i[7:6]);
            addr       <= ulpi_data_i[5:0];
            cnt        <= '0;
            ulpi_nxt_o <= ND == 2'd0;
          end
        S_CMD_WAIT:
          if (ulpi_stp_i) begin
            state      <= S_IDLE;
            ulpi_nxt_o <= 1'b0;
          end else if (ulpi_nxt_o) begin
            state      <= cmd == CMD_RD ? S_RD_TURN1 : cmd == CMD_WR ? S_WR_DATA : S_TX;
            ulpi_nxt_o <= cmd != CMD_RD;
            ulpi_dir_o <= cmd == CMD_RD;
          end else begin
            cnt        <= cnt + 2'd1;
            ulpi_nxt_o <= cnt + 2'd1 == ND;
          end
        S_WR_DATA: begin
          wdata      <= ulpi_data_i;
          ulpi_nxt_o <= 1'b0;
          state      <= ulpi_stp_i ? S_IDLE : S_WR_STP;
        end
        S_WR_STP:
          if (ulpi_stp_i) state <= S_IDLE;
        S_RD_TURN1: begin
          state       <= S_RD_DATA;
          ulpi_data_o <= rdata;
        end
        S_RD_DATA: begin
          state       <= S_RD_TURN2;
          ulpi_dir_o  <= 1'b0;
          ulpi_data_o <= 8'h00;
        end
        S_RD_TURN2: state <= S_IDLE;
        S_TX:
          if (ulpi_stp_i) begin
            state      <= S_IDLE;
            ulpi_nxt_o <= 1'b0;
          end
`ifdef ULPI_PHY_RXCMD_EN
        S_RX_TURN1: begin
          state       <= S_RX_DATA;
          ulpi_data_o <= {6'b0, last_ls};
        end
        S_RX_DATA: begin
          state       <= S_RX_TURN2;
          ulpi_dir_o  <= 1'b0;
          ulpi_data_o <= 8'h00;
        end
        S_RX_TURN2: state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_ulpi_phy_reg_model.sv
// tb_ulpi_phy_reg_model: two DUTs (NXT_DELAY 0 and 3), random ULPI traffic scored against a register model
module tb_ulpi_phy_reg_model;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][7:0] din, dout, fc;
  logic [1:0][1:0] ls;
  logic [1:0]      stp, dir, nxt;

  int total = 0;
  int bad = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int dcnt [2];
  logic [7:0] m [2][4];

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    ulpi_phy_reg_model #(.NXT_DELAY(g * 3)) dut (
      .ulpi_clk60_i (clk),
      .ulpi_rst_i   (rst),
      .ulpi_data_i  (din[g]),
      .ulpi_data_o  (dout[g]),
      .ulpi_dir_o   (dir[g]),
      .ulpi_nxt_o   (nxt[g]),
      .ulpi_stp_i   (stp[g]),
      .linestate_i  (ls[g]),
      .func_ctrl_o  (fc[g])
    );
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Register model: each register reachable at base/base+1/base+2 as write/set/clear
  function automatic int reg_index(input logic [5:0] a);
    int bases [4] = '{4, 7, 10, 22};
    for (int i = 0; i < 4; i++)
      if (int'(a) >= bases[i] && int'(a) <= bases[i] + 2) return i;
    return -1;
  endfunction

  function automatic int reg_offset(input logic [5:0] a);
    int bases [4] = '{4, 7, 10, 22};
    int i = reg_index(a);
    return i < 0 ? 0 : int'(a) - bases[i];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m[s][0] = 8'h41;
      m[s][1] = 8'h00;
      m[s][2] = 8'h06;
      m[s][3] = 8'h00;
    end
  endtask

  task automatic model_write(input int s, input logic [5:0] a, input logic [7:0] d);
    int i = reg_index(a);
    int o = reg_offset(a);
    if (i >= 0) begin
      if (o == 0) m[s][i] = d;
      else if (o == 1) m[s][i] = m[s][i] | d;
      else m[s][i] = m[s][i] & ~d;
      if (i == 0) m[s][0][5] = 1'b0;
    end
  endtask

  function automatic logic [7:0] model_read(input int s, input logic [5:0] a);
    int i = reg_index(a);
    if (a == 6'h00) return 8'h24;
    if (a == 6'h01) return 8'h04;
    if (a == 6'h02) return 8'h09;
    if (a == 6'h03) return 8'h00;
    return i < 0 ? 8'h00 : m[s][i];
  endfunction

  task automatic push(input int s, input logic [7:0] v);
    if (s == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  // Monitor: second cycle of every dir=1 frame carries a byte that must match the scoreboard
  task automatic mon(input int s);
    logic [7:0] e;
    if (rst) dcnt[s] = 0;
    else if (dir[s]) begin
      dcnt[s]++;
      if (dcnt[s] == 2) begin
        if ((s == 0 ? q0.size() : q1.size()) == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame dut%0d: got byte %h, required no frame", s, dout[s]);
        end else begin
          if (s == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk($sformatf("frame_byte dut%0d", s), dout[s], e);
        end
      end
    end else begin
      if (dcnt[s] != 0) chk($sformatf("frame_len dut%0d", s), 8'(dcnt[s]), 8'd2);
      dcnt[s] = 0;
      chk($sformatf("idle_data dut%0d", s), dout[s], 8'h00);
    end
  endtask

  always @(negedge clk) for (int s = 0; s < 2; s++) mon(s);

  // All bus tasks start and end at a negedge with the DUT idle
  task automatic send_cmd(input int s, input logic [7:0] c, output bit ok);
    int k = 0;
    din[s] = c;
    do begin
      @(negedge clk);
      k++;
    end while (!nxt[s] && k < 10);
    ok = nxt[s];
    chk($sformatf("nxt_latency dut%0d cmd %h", s, c), 8'(k), 8'(s * 3 + 1));
    if (!ok) begin
      din[s] = 8'h00;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic reg_write(input int s, input logic [5:0] a, input logic [7:0] d, input bit discard);
    bit ok;
    send_cmd(s, {2'b10, a}, ok);
    if (!ok) return;
    @(negedge clk);
    chk($sformatf("wr_data_nxt dut%0d", s), {7'b0, nxt[s]}, 8'h01);
    din[s] = d;
    stp[s] = discard;
    @(negedge clk);
    din[s] = 8'h00;
    stp[s] = !discard;
    @(negedge clk);
    stp[s] = 1'b0;
    if (!discard) model_write(s, a, d);
  endtask

  task automatic reg_read(input int s, input logic [5:0] a, input bit abort);
    bit ok;
    if (!abort) push(s, model_read(s, a));
    send_cmd(s, {2'b11, a}, ok);
    if (!ok) return;
    din[s] = 8'h00;
    if (abort) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("reset_dir", {7'b0, dir[s]}, 8'h00);
      chk("reset_nxt", {7'b0, nxt[s]}, 8'h00);
      chk("reset_data", dout[s], 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      return;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic tx(input int s, input int n);
    bit ok;
    send_cmd(s, {2'b01, 6'($urandom)}, ok);
    if (!ok) return;
    for (int i = 0; i < n; i++) begin
      din[s] = 8'($urandom);
      @(negedge clk);
      chk($sformatf("tx_nxt dut%0d", s), {7'b0, nxt[s]}, 8'h01);
    end
    stp[s] = 1'b1;
    din[s] = 8'h00;
    @(negedge clk);
    stp[s] = 1'b0;
    chk($sformatf("tx_end_nxt dut%0d", s), {7'b0, nxt[s]}, 8'h00);
  endtask

  task automatic noop(input int s);
    din[s] = {2'b00, 6'($urandom)};
    @(negedge clk);
    din[s] = 8'h00;
    repeat (s * 3) @(negedge clk);
    chk($sformatf("noop_nxt dut%0d", s), {7'b0, nxt[s]}, 8'h00);
  endtask

  function automatic logic [5:0] pick_addr();
    int r = $urandom_range(0, 9);
    if (r < 6) return 6'($urandom_range(0, 12));
    if (r < 8) return 6'($urandom_range(22, 24));
    return 6'($urandom);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int s, op, seen;
    logic [5:0] a;
    din = '0;
    stp = '0;
    ls = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_dir", {7'b0, dir[0]}, 8'h00);
    chk("rst_nxt", {7'b0, nxt[0]}, 8'h00);
    chk("rst_data", dout[0], 8'h00);
    chk("rst_func0", fc[0], 8'h41);
    chk("rst_func1", fc[1], 8'h41);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) reg_read(0, 6'(i), 1'b0);
    reg_read(0, 6'h04, 1'b0);
    reg_write(0, 6'h04, 8'h20, 1'b0);
    chk("func_reset_set", fc[0], 8'h20);
    @(negedge clk);
    chk("func_reset_clr", fc[0], 8'h00);
    reg_read(0, 6'h06, 1'b0);

    reg_write(0, 6'h16, 8'hA5, 1'b0);
    reg_write(0, 6'h17, 8'h0A, 1'b0);
    reg_write(0, 6'h18, 8'h21, 1'b0);
    reg_read(0, 6'h16, 1'b0);
    chk("scratch_model", m[0][3], 8'h8E);

    reg_write(0, 6'h00, 8'hFF, 1'b0);
    reg_read(0, 6'h00, 1'b0);
    reg_write(0, 6'h3F, 8'h5A, 1'b0);
    reg_read(0, 6'h3F, 1'b0);
    reg_write(0, 6'h16, 8'h11, 1'b1);
    reg_read(0, 6'h17, 1'b0);

    din[1] = 8'h96;
    @(negedge clk);
    stp[1] = 1'b1;
    seen = nxt[1];
    @(negedge clk);
    stp[1] = 1'b0;
    din[1] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      seen = seen | int'(nxt[1]);
      @(negedge clk);
    end
    chk("abort_no_nxt", 8'(seen), 8'h00);
    reg_read(1, 6'h16, 1'b0);

    reg_read(0, 6'h0A, 1'b1);
    chk("post_reset_func", fc[0], 8'h41);
    reg_read(0, 6'h0A, 1'b0);

    for (int i = 0; i < 160; i++) begin
      s = $urandom_range(0, 3) == 0 ? 1 : 0;
      a = pick_addr();
      op = $urandom_range(0, 6);
`ifndef ULPI_PHY_RXCMD_EN
      ls[0] = 2'($urandom);
      ls[1] = 2'($urandom);
`endif
      if (op < 2) reg_read(s, a, 1'b0);
      else if (op < 4) reg_write(s, a, 8'($urandom), 1'b0);
      else if (op == 4) reg_write(s, a, 8'($urandom), 1'b1);
      else if (op == 5) tx(s, $urandom_range(0, 4));
      else noop(s);
    end
    for (int i = 0; i < 4; i++) reg_read(0, 6'h04 + 6'(i * 3), 1'b0);
    reg_read(0, 6'h16, 1'b0);

`ifdef ULPI_PHY_RXCMD_EN
    push(0, 8'h01);
    ls[0] = 2'b01;
    repeat (5) @(negedge clk);
    push(0, 8'h00);
    ls[0] = 2'b00;
    repeat (5) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    chk("queue0_empty", 8'(q0.size()), 8'h00);
    chk("queue1_empty", 8'(q1.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
